// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: input synchronizers, button debouncers, RUN/PAUSED/ADJUST
// sequencing, a shared 1 s / 2 Hz prescaler pair and the MM:SS counter.
module stopwatch_ctrl #(
    parameter int TICK_CYCLES = 100000000,
    parameter int DB_CYCLES   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       paused,
    output logic       adj_active,
    output logic       blink,
    output logic       sec_tick
);

    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int AW = (TICK_CYCLES > 4) ? $clog2(TICK_CYCLES / 2) : 1;
    localparam int DW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_ADJUST} state_t;

    // Bit order: 0 = pause, 1 = clear, 2 = adjust switch, 3 = select switch
    logic [3:0] raw_in;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [1:0] press;

    assign raw_in = {sw_sel, sw_adj, btn_clear, btn_pause};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            logic [DW-1:0] cnt_q;
            logic          lvl_q;
            logic          dly_q;
            logic          press_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q   <= '0;
                    lvl_q   <= 1'b0;
                    dly_q   <= 1'b0;
                    press_q <= 1'b0;
                end else begin
                    if (sync2_q[gi] == lvl_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DW'(DB_CYCLES - 1)) begin
                        cnt_q <= '0;
                        lvl_q <= ~lvl_q;
                    end else begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                    dly_q   <= lvl_q;
                    press_q <= lvl_q & ~dly_q;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    logic pause_press;
    logic clear_press;
    logic adj_s;
    logic sel_s;

    assign pause_press = press[0];
    assign clear_press = press[1];
    assign adj_s       = sync2_q[2];
    assign sel_s       = sync2_q[3];

    state_t        state_q, state_d;
    logic [TW-1:0] presc_q, presc_d;
    logic [AW-1:0] adj_presc_q, adj_presc_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          blink_q, blink_d;
    logic          tick_q, tick_d;
    logic          paused_q, adj_q;
    logic          in_run, in_adj, adj_entry, sec_wrap, adj_wrap;

    always_comb begin
        state_d = state_q;
        if (adj_s) begin
            state_d = ST_ADJUST;
        end else begin
            case (state_q)
                ST_RUN:    if (pause_press) state_d = ST_PAUSED;
                ST_PAUSED: if (pause_press) state_d = ST_RUN;
                ST_ADJUST: state_d = ST_PAUSED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        in_run    = (state_q == ST_RUN);
        in_adj    = (state_q == ST_ADJUST);
        adj_entry = (state_d == ST_ADJUST) && !in_adj;
        sec_wrap  = in_run && (presc_q == TW'(TICK_CYCLES - 1));
        adj_wrap  = in_adj && (adj_presc_q == AW'(TICK_CYCLES / 2 - 1));

        presc_d = presc_q;
        if (clear_press || adj_entry) presc_d = '0;
        else if (sec_wrap)            presc_d = '0;
        else if (in_run)              presc_d = presc_q + TW'(1);

        adj_presc_d = adj_presc_q;
        if (clear_press || adj_entry) adj_presc_d = '0;
        else if (adj_wrap)            adj_presc_d = '0;
        else if (in_adj)              adj_presc_d = adj_presc_q + AW'(1);

        // Clear wins over any coincident tick, including the sec_tick pulse itself
        tick_d = sec_wrap && !clear_press;

        min_d = min_q;
        sec_d = sec_q;
        if (clear_press) begin
            min_d = '0;
            sec_d = '0;
        end else if (sec_wrap) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (adj_wrap) begin
            if (sel_s) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            else       min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end

        blink_d = 1'b0;
        if (in_adj && (state_d == ST_ADJUST)) blink_d = blink_q ^ adj_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            presc_q     <= '0;
            adj_presc_q <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            blink_q     <= 1'b0;
            tick_q      <= 1'b0;
            paused_q    <= 1'b0;
            adj_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            adj_presc_q <= adj_presc_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            blink_q     <= blink_d;
            tick_q      <= tick_d;
            paused_q    <= (state_d == ST_PAUSED);
            adj_q       <= (state_d == ST_ADJUST);
        end
    end

    assign min        = min_q;
    assign sec        = sec_q;
    assign paused     = paused_q;
    assign adj_active = adj_q;
    assign blink      = blink_q;
    assign sec_tick   = tick_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at TICK_CYCLES=10, DB_CYCLES=4; e counts clock
// edges since reset release and all driving/sampling happens on the falling edge.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_clear = 1'b0;
    logic       sw_adj = 1'b0;
    logic       sw_sel = 1'b0;
    logic [5:0] min;
    logic [5:0] sec;
    logic       paused;
    logic       adj_active;
    logic       blink;
    logic       sec_tick;

    int compared   = 0;
    int mismatched = 0;
    int e          = 0;
    int ticks;
    int last;
    int n;

    stopwatch_ctrl #(.TICK_CYCLES(10), .DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_clear(btn_clear),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .min(min), .sec(sec), .paused(paused),
        .adj_active(adj_active), .blink(blink), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        $display("t=%0t e=%0d check %s observed %0d expected %0d", $time, e, tag, obs, exp);
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (e < t) begin
            @(negedge clk);
            e++;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_min", min, 0);
        chk("rst_sec", sec, 0);
        chk("rst_paused", paused, 0);
        chk("rst_adj", adj_active, 0);
        chk("rst_blink", blink, 0);
        chk("rst_tick", sec_tick, 0);
        @(negedge clk);
        rst = 1'b0;
        e   = 0;

        // Free run: ticks at edges 10,20,...,120
        ticks = 0;
        last  = 0;
        for (int k = 0; k < 125; k++) begin
            goto(e + 1);
            if (sec_tick) begin
                ticks++;
                chk("tick_spacing", e - last, 10);
                last = e;
            end
        end
        chk("run_tick_count", ticks, 12);
        chk("run_sec", sec, 12);
        chk("run_min", min, 0);
        chk("run_paused", paused, 0);

        // Bouncy pause press, final rise at e=146 -> press at 153, PAUSED at 154
        goto(134);
        for (int b = 0; b < 3; b++) begin
            btn_pause = 1'b1;
            goto(e + 2);
            btn_pause = 1'b0;
            goto(e + 2);
        end
        btn_pause = 1'b1;
        goto(153);
        chk("bounce_not_yet_paused", paused, 0);
        goto(154);
        chk("bounce_paused", paused, 1);
        chk("bounce_sec", sec, 15);
        goto(166);
        btn_pause = 1'b0;
        ticks = 0;
        for (int k = 0; k < 100; k++) begin
            goto(e + 1);
            if (sec_tick) ticks++;
        end
        chk("paused_no_ticks", ticks, 0);
        chk("paused_sec_hold", sec, 15);
        chk("paused_after_release", paused, 1);

        // Resume with prescaler held at 4: RUN at 274, tick 6 edges later
        btn_pause = 1'b1;
        goto(273);
        chk("resume_still_paused", paused, 1);
        goto(274);
        chk("resume_run", paused, 0);
        n = 0;
        while (!sec_tick && n < 20) begin
            goto(e + 1);
            n++;
        end
        chk("resume_latency", n, 6);
        chk("resume_sec", sec, 16);
        btn_pause = 1'b0;

        // Clear landing on the prescaler-at-9 cycle (effective edge 290)
        goto(282);
        btn_clear = 1'b1;
        goto(289);
        chk("pre_clear_sec", sec, 16);
        goto(290);
        chk("clear9_sec", sec, 0);
        chk("clear9_min", min, 0);
        chk("clear9_tick_suppressed", sec_tick, 0);
        goto(292);
        btn_clear = 1'b0;
        goto(300);
        chk("post_clear_tick", sec_tick, 1);
        chk("post_clear_sec", sec, 1);
        goto(360);
        chk("at_0007_sec", sec, 7);

        // ADJUST minutes from 00:07; state ADJUST at 363, adj_tick every 5 edges
        sw_adj = 1'b1;
        sw_sel = 1'b0;
        goto(362);
        chk("adj_not_yet", adj_active, 0);
        goto(363);
        chk("adj_active", adj_active, 1);
        chk("adj_entry_blink", blink, 0);
        chk("adj_not_paused", paused, 0);
        goto(367);
        chk("adj_min_before_tick", min, 0);
        goto(368);
        chk("adj_min_1", min, 1);
        chk("adj_blink_1", blink, 1);
        chk("adj_sec_hold", sec, 7);
        goto(373);
        chk("adj_min_2", min, 2);
        chk("adj_blink_0", blink, 0);
        goto(658);
        chk("adj_min_59", min, 59);
        chk("adj_sec_still_7", sec, 7);
        sw_sel = 1'b1;
        goto(663);
        chk("sel_sec_8", sec, 8);
        chk("sel_min_hold", min, 59);
        goto(918);
        chk("sel_sec_59", sec, 59);
        goto(923);
        chk("sel_sec_wrap", sec, 0);
        chk("sel_no_carry", min, 59);
        goto(1213);
        chk("sel_sec_58", sec, 58);
        sw_adj = 1'b0;
        goto(1215);
        chk("exit_adj_pending", adj_active, 1);
        goto(1216);
        chk("exit_adj", adj_active, 0);
        chk("exit_paused", paused, 1);
        chk("exit_blink", blink, 0);
        chk("exit_min", min, 59);
        chk("exit_sec", sec, 58);

        // Resume from 59:58 with prescaler cleared by ADJUST entry
        btn_pause = 1'b1;
        goto(1224);
        chk("wrap_run", paused, 0);
        goto(1226);
        btn_pause = 1'b0;
        goto(1233);
        chk("wrap_no_tick_yet", sec_tick, 0);
        goto(1234);
        chk("wrap_tick_5959", sec_tick, 1);
        chk("wrap_sec_59", sec, 59);
        chk("wrap_min_59", min, 59);
        goto(1244);
        chk("wrap_tick_0000", sec_tick, 1);
        chk("wrap_sec_0", sec, 0);
        chk("wrap_min_0", min, 0);

        // Clear mid-second (prescaler at 1) pushes the next tick from 1274 to 1276
        goto(1254);
        chk("mid_sec_1", sec, 1);
        goto(1258);
        btn_clear = 1'b1;
        goto(1266);
        chk("mid_clear_sec", sec, 0);
        goto(1268);
        btn_clear = 1'b0;
        goto(1274);
        chk("mid_clear_no_tick", sec_tick, 0);
        goto(1276);
        chk("mid_clear_tick", sec_tick, 1);
        chk("mid_clear_sec_1", sec, 1);

        // Asynchronous reset in the middle of ADJUST
        sw_adj = 1'b1;
        sw_sel = 1'b0;
        goto(1294);
        chk("adj2_min", min, 3);
        chk("adj2_blink", blink, 1);
        chk("adj2_active", adj_active, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_min", min, 0);
        chk("arst_sec", sec, 0);
        chk("arst_paused", paused, 0);
        chk("arst_adj", adj_active, 0);
        chk("arst_blink", blink, 0);
        chk("arst_tick", sec_tick, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and timekeeping core for the stopwatch.
- Debounces the pause and clear buttons and synchronizes the adjust and select switches.
- Sequences a RUN/PAUSED/ADJUST state machine that gates a master-clock prescaler, and maintains the MM:SS count.
- Sits between board I/O and the display/seven-segment path, replacing free-running per-rate dividers with one scheduled tick source.

Parameters:
- TICK_CYCLES, 100000000: master-clock cycles per 1 s tick; must be even and ≥4.
- DB_CYCLES, 1000000: consecutive stable synchronized samples required to accept a button level change.

Ports:
- clk  in  1  master clock.
- rst  in  1  asynchronous, active-high reset.
- btn_pause  in  1  raw pause/resume button; asynchronous, bouncy.
- btn_clear  in  1  raw clear button; asynchronous, bouncy.
- sw_adj  in  1  adjust-mode switch; asynchronous.
- sw_sel  in  1  adjust field select: 0 = minutes, 1 = seconds.
- min  out  6  minutes, binary 0..59.
- sec  out  6  seconds, binary 0..59.
- paused  out  1  high in PAUSED.
- adj_active  out  1  high in ADJUST.
- blink  out  1  display blink phase for the selected field; 0 outside ADJUST.
- sec_tick  out  1  one-cycle pulse on each counted second.

Behaviour:
- Reset (rst=1, asynchronous):
  - min, sec, sec_tick and blink go to 0.
  - State goes to RUN: paused=0, adj_active=0.
  - Prescalers, synchronizers and debounce state clear; debounced levels are 0.
- Input synchronization: every input passes through 2 flops; all logic uses the synchronized values.
- Debounce, per button:
  - A counter runs while the synchronized value differs from the debounced level; any agreement resets it.
  - When the counter reaches DB_CYCLES, the debounced level flips.
  - A press pulse fires for exactly one cycle on the cycle after the debounced level rises.
  - Raw edge to press pulse = DB_CYCLES+3 clk cycles.
  - Release produces no pulse. Bounces shorter than DB_CYCLES produce no pulse.
- FSM:
  - Any state with adj_s=1 goes to ADJUST. This has highest priority.
  - RUN → PAUSED on pause press.
  - PAUSED → RUN on pause press.
  - ADJUST → PAUSED when adj_s=0.
  - Pause presses in ADJUST are ignored and not queued.
- Main prescaler:
  - Counts 0..TICK_CYCLES-1 only in RUN. At TICK_CYCLES-1 it wraps to 0 and sec_tick=1 that cycle.
  - Holds its value in PAUSED, so resume continues the partial second.
  - Cleared on entry to ADJUST.
- Time update on sec_tick:
  - sec<59: sec+1.
  - sec=59: sec=0, and min=(min==59)?0:min+1.
  - 59:59 wraps to 00:00.
- ADJUST:
  - The adjust prescaler counts 0..TICK_CYCLES/2-1. At wrap it produces adj_tick (2 Hz) and toggles blink.
  - adj_tick increments the selected field mod 60, with no carry between fields.
  - Changing sw_sel mid-ADJUST takes effect on the next adj_tick; the prescaler is not cleared.
  - On entry to ADJUST, the adjust prescaler clears and blink=0. On exit, blink=0.
- Clear press:
  - In the same cycle: min=sec=0 and both prescalers clear.
  - State is unchanged, and it is valid in every state.
  - Overrides a coincident sec_tick or adj_tick: the result is 00:00 and sec_tick is suppressed.
- Simultaneous pause press and sec_tick in RUN: the tick's time update is applied, sec_tick pulses, then the state becomes PAUSED.
- Outputs min, sec, paused, adj_active and blink are registered. sec_tick is registered coincident with the counter update.

Test Plan (TICK_CYCLES=10, DB_CYCLES=4):
- Release rst, idle 125 cycles → exactly 12 sec_tick pulses, 10 cycles apart; sec=12, min=0.
- btn_pause pulsed with three 2-cycle bounces then held 20 cycles → exactly one press pulse, DB_CYCLES+3=7 cycles after the final rising edge; paused=1; sec holds for 100 cycles.
- Preload 59:58, run 20 cycles → passes 59:59 → 00:00 with sec_tick each step.
- With prescaler at 4 when paused, press pause again → first sec_tick arrives 6 cycles after RUN is re-entered.
- Set sw_adj=1, sw_sel=0 at 00:07 → min increments every 5 cycles, blink toggles every 5 cycles, and sec stays 7. Set sw_sel=1 at sec=59 → next adj_tick gives sec=0 with min unchanged. sw_adj=0 → paused=1, blink=0.
- Assert clear press on the same cycle the prescaler reaches 9 → min=sec=0, sec_tick=0. Assert rst mid-ADJUST → all outputs return to reset values immediately, without waiting for a clock edge.
